// File: rtl/dk_sound_sequencer.sv
// Trigger sequencer and shared sample-strobe generator for the discrete sound blocks.
// Optional mute input enabled by defining DK_SEQ_MUTE_EN.
module dk_sound_sequencer #(
    parameter int CLOCK_RATE         = 48000000,
    parameter int SAMPLE_RATE        = 48000,
    parameter int NUM_CH             = 4,
    parameter int MIN_HOLD_SAMPLES   = 2400,
    parameter int RETRIG_GAP_SAMPLES = 48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] trig_in,
`ifdef DK_SEQ_MUTE_EN
    input  logic              mute,
`endif
    output logic              audio_clk_en,
    output logic [NUM_CH-1:0] sound_en,
    output logic [NUM_CH-1:0] busy
);
    localparam int ACC_W  = $clog2(CLOCK_RATE + SAMPLE_RATE);
    localparam int HOLD_W = $clog2(MIN_HOLD_SAMPLES + 1);
    localparam int GAP_W  = (RETRIG_GAP_SAMPLES > 0) ? $clog2(RETRIG_GAP_SAMPLES + 1) : 1;

    localparam logic [ACC_W-1:0]  ACC_STEP  = ACC_W'(SAMPLE_RATE);
    localparam logic [ACC_W-1:0]  ACC_WRAP  = ACC_W'(CLOCK_RATE);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD_SAMPLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(RETRIG_GAP_SAMPLES);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_SUSTAIN,
        S_GAP
    } state_t;

    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_acc_sum;
    logic              r_stb;
    logic [NUM_CH-1:0] r_trig_q;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_fall;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_to_gap;
    logic [NUM_CH-1:0] r_sound_en;
    logic [NUM_CH-1:0] r_busy;
    state_t            r_state [NUM_CH];
    state_t            w_state [NUM_CH];
    logic [HOLD_W-1:0] r_hold  [NUM_CH];
    logic [HOLD_W-1:0] w_hold  [NUM_CH];
    logic [GAP_W-1:0]  r_gap   [NUM_CH];
    logic [GAP_W-1:0]  w_gap   [NUM_CH];

    assign w_acc_sum = r_acc + ACC_STEP;
    assign w_rise    = trig_in & ~r_trig_q;
    assign w_fall    = ~trig_in & r_trig_q;

    always_comb begin
        w_pend   = r_pend;
        w_to_gap = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_state[c] = r_state[c];
            w_hold[c]  = r_hold[c];
            w_gap[c]   = r_gap[c];
            unique case (r_state[c])
                S_IDLE: begin
                    if (w_rise[c]) begin
                        w_state[c] = S_HOLD;
                        w_hold[c]  = HOLD_LOAD;
                    end
                end
                S_HOLD: begin
                    // A fresh trigger restarts the minimum hold, even on a strobe cycle.
                    if (w_rise[c]) begin
                        w_hold[c] = HOLD_LOAD;
                    end else if (r_stb) begin
                        w_hold[c] = r_hold[c] - HOLD_ONE;
                        if (r_hold[c] == HOLD_ONE) begin
                            if (trig_in[c]) w_state[c] = S_SUSTAIN;
                            else            w_to_gap[c] = 1'b1;
                        end
                    end
                end
                S_SUSTAIN: begin
                    if (w_fall[c]) w_to_gap[c] = 1'b1;
                end
                S_GAP: begin
                    if (w_rise[c]) w_pend[c] = 1'b1;
                    if (r_stb) begin
                        w_gap[c] = r_gap[c] - GAP_ONE;
                        if (r_gap[c] == GAP_ONE) begin
                            w_state[c] = (r_pend[c] || w_rise[c]) ? S_HOLD : S_IDLE;
                            w_hold[c]  = HOLD_LOAD;
                            w_pend[c]  = 1'b0;
                        end
                    end
                end
            endcase
            if (w_to_gap[c]) begin
                w_state[c] = (RETRIG_GAP_SAMPLES == 0) ? S_IDLE : S_GAP;
                w_gap[c]   = GAP_LOAD;
                w_pend[c]  = 1'b0;
            end
`ifdef DK_SEQ_MUTE_EN
            if (mute) begin
                w_state[c] = S_IDLE;
                w_pend[c]  = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_stb      <= 1'b0;
            r_trig_q   <= '1;
            r_pend     <= '0;
            r_sound_en <= '0;
            r_busy     <= '0;
            for (int c = 0; c < NUM_CH; c++) r_state[c] <= S_IDLE;
        end else begin
            // Phase accumulator: exactly SAMPLE_RATE strobes per CLOCK_RATE cycles.
            if (w_acc_sum >= ACC_WRAP) begin
                r_acc <= w_acc_sum - ACC_WRAP;
                r_stb <= 1'b1;
            end else begin
                r_acc <= w_acc_sum;
                r_stb <= 1'b0;
            end
            r_trig_q <= trig_in;
            r_pend   <= w_pend;
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c]    <= w_state[c];
                r_sound_en[c] <= (w_state[c] == S_HOLD) || (w_state[c] == S_SUSTAIN);
                r_busy[c]     <= (w_state[c] != S_IDLE);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            r_hold[c] <= w_hold[c];
            r_gap[c]  <= w_gap[c];
        end
    end

    assign audio_clk_en = r_stb;
    assign sound_en     = r_sound_en;
    assign busy         = r_busy;

endmodule

// File: tb/tb_dk_sound_sequencer.sv
// Self-checking bench for dk_sound_sequencer: behavioural model plus directed and random stimulus.
module tb_dk_sound_sequencer;
    localparam int CR     = 120000;
    localparam int SR     = 48000;
    localparam int NUM_CH = 4;
    localparam int MINH   = 4;
    localparam int GAPS   = 2;

    logic              clk;
    logic              reset;
    logic [NUM_CH-1:0] trig_in;
`ifdef DK_SEQ_MUTE_EN
    logic              mute;
`endif
    logic              audio_clk_en;
    logic [NUM_CH-1:0] sound_en;
    logic [NUM_CH-1:0] busy;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state
    longint            m_edges;
    bit                m_stb;
    bit [NUM_CH-1:0]   m_trig_q;
    bit [NUM_CH-1:0]   m_en;
    bit [NUM_CH-1:0]   m_pend;
    int                m_hold [NUM_CH];
    int                m_gap  [NUM_CH];

    dk_sound_sequencer #(
        .CLOCK_RATE(CR), .SAMPLE_RATE(SR), .NUM_CH(NUM_CH),
        .MIN_HOLD_SAMPLES(MINH), .RETRIG_GAP_SAMPLES(GAPS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .trig_in(trig_in),
`ifdef DK_SEQ_MUTE_EN
        .mute(mute),
`endif
        .audio_clk_en(audio_clk_en),
        .sound_en(sound_en),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic release_ch(input int c);
        m_en[c]   = 1'b0;
        m_gap[c]  = GAPS;
        m_pend[c] = 1'b0;
    endtask

    // Model of one clock edge; the strobe that gates counting is the one already visible.
    task automatic model_edge();
        bit [NUM_CH-1:0] rise;
        bit [NUM_CH-1:0] fall;
        rise = trig_in & ~m_trig_q;
        fall = ~trig_in & m_trig_q;
        if (reset) begin
            m_edges = 0; m_stb = 1'b0; m_trig_q = '1; m_en = '0; m_pend = '0;
            for (int c = 0; c < NUM_CH; c++) begin m_hold[c] = 0; m_gap[c] = 0; end
            return;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (m_gap[c] > 0) begin
                if (rise[c]) m_pend[c] = 1'b1;
                if (m_stb) begin
                    m_gap[c]--;
                    if (m_gap[c] == 0) begin
                        if (m_pend[c]) begin m_en[c] = 1'b1; m_hold[c] = MINH; end
                        m_pend[c] = 1'b0;
                    end
                end
            end else if (m_en[c]) begin
                if (rise[c]) m_hold[c] = MINH;
                else if (m_hold[c] > 0) begin
                    if (m_stb) begin
                        m_hold[c]--;
                        if (m_hold[c] == 0 && !trig_in[c]) release_ch(c);
                    end
                end else if (fall[c]) release_ch(c);
            end else if (rise[c]) begin
                m_en[c] = 1'b1; m_hold[c] = MINH;
            end
`ifdef DK_SEQ_MUTE_EN
            if (mute) begin m_en[c] = 1'b0; m_gap[c] = 0; m_pend[c] = 1'b0; end
`endif
        end
        m_trig_q = trig_in;
        m_edges++;
        m_stb = ((m_edges * SR) / CR) != (((m_edges - 1) * SR) / CR);
    endtask

    task automatic step();
        bit [NUM_CH-1:0] exp_busy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) exp_busy[c] = m_en[c] || (m_gap[c] > 0);
        chk("audio_clk_en", 32'(audio_clk_en), 32'(m_stb));
        chk("sound_en", 32'(sound_en), 32'(m_en));
        chk("busy", 32'(busy), 32'(exp_busy));
    endtask

    task automatic pulse(input int c);
        trig_in[c] = 1'b1; step(); trig_in[c] = 1'b0;
    endtask

    task automatic count_while_en(input int c, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (!sound_en[c]) break;
            if (audio_clk_en) n++;
            step();
        end
    endtask

    task automatic count_gap(input int c, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy[c]) break;
            if (audio_clk_en && !sound_en[c]) n++;
            step();
        end
    endtask

    initial begin
        int n, first, second;
        reset = 1'b1; trig_in = '0;
`ifdef DK_SEQ_MUTE_EN
        mute = 1'b0;
`endif
        step(); step();
        chk("reset_sound_en", 32'(sound_en), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_stb", 32'(audio_clk_en), 32'd0);

        // Strobe cadence
        reset = 1'b0; n = 0; first = 0; second = 0;
        for (int i = 1; i <= 5000; i++) begin
            step();
            if (audio_clk_en) begin
                n++;
                if (n == 1) first = i;
                if (n == 2) second = i;
            end
        end
        chk("first_strobe", 32'(first), 32'd3);
        chk("second_strobe", 32'(second), 32'd5);
        chk("strobe_total", 32'(n), 32'd2000);

        // Single pulse: 4-strobe hold then 2-strobe gap
        pulse(0);
        chk("pulse_en", 32'(sound_en), 32'b0001);
        count_while_en(0, n);
        chk("pulse_hold_strobes", 32'(n), 32'd4);
        count_gap(0, n);
        chk("pulse_gap_strobes", 32'(n), 32'd2);

        // Held trigger sustains until release
        trig_in[1] = 1'b1; step(); n = 0;
        for (int i = 0; i < 200 && n < 20; i++) begin
            if (audio_clk_en) n++;
            step();
        end
        chk("sustain_en", 32'(sound_en[1]), 32'd1);
        trig_in[1] = 1'b0; step();
        chk("sustain_drop", 32'(sound_en[1]), 32'd0);
        chk("sustain_gap_busy", 32'(busy[1]), 32'd1);
        count_gap(1, n);
        chk("sustain_gap_strobes", 32'(n), 32'd2);

        // Retrigger during gap, then reload during hold
        pulse(2);
        count_while_en(2, n);
        pulse(2);
        chk("gap_retrig_low", 32'(sound_en[2]), 32'd0);
        for (int i = 0; i < 50 && !sound_en[2]; i++) step();
        count_while_en(2, n);
        chk("gap_retrig_hold", 32'(n), 32'd4);
        for (int i = 0; i < 50 && busy[2]; i++) step();
        pulse(2); n = 0;
        for (int i = 0; i < 50 && n < 2; i++) begin
            if (audio_clk_en) n++;
            if (n < 2) step();
        end
        pulse(2);
        count_while_en(2, n);
        chk("reload_hold", 32'(n), 32'd4);
        for (int i = 0; i < 50 && busy[2]; i++) step();

        // Reset mid-hold with trigger held high
        trig_in[0] = 1'b1; step(); step();
        reset = 1'b1; step(); reset = 1'b0;
        chk("midreset_en", 32'(sound_en), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 10; i++) step();
        chk("midreset_no_retrig", 32'(sound_en[0]), 32'd0);
        trig_in[0] = 1'b0; step();
        pulse(0);
        chk("midreset_new_rise", 32'(sound_en[0]), 32'd1);
        for (int i = 0; i < 50 && busy[0]; i++) step();

`ifdef DK_SEQ_MUTE_EN
        trig_in[0] = 1'b1; trig_in[3] = 1'b1; step();
        trig_in[0] = 1'b0; trig_in[3] = 1'b0; step();
        mute = 1'b1; step();
        chk("mute_en", 32'({sound_en[3], sound_en[0]}), 32'd0);
        mute = 1'b0; step();
        pulse(0);
        chk("unmute_retrig", 32'(sound_en[0]), 32'd1);
`endif

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 29) == 0) trig_in[c] = ~trig_in[c];
            reset = ($urandom_range(0, 999) == 0);
`ifdef DK_SEQ_MUTE_EN
            mute = ($urandom_range(0, 149) == 0);
`endif
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
